sdram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single 16-bit Avalon-MM SDRAM controller port (25-bit word address, active-low read/write/byteenable, waitrequest, pipelined readdatavalid) between a write-side requester (m0, capture/FIFO fill) and a read-side requester (m1, display/FIFO drain). It sits between the FIFO logic and the SDRAM port of the RAMSYS system. It grants the port in bounded bursts and tracks outstanding reads so each readdatavalid is routed back to the requester that issued it.

---
 rtl/sdram_arb_pkg.sv | 35 +++
 rtl/sdram_arb_tag_fifo.sv | 52 +++++
 rtl/sdram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared widths, requester id, state encoding and arbitration helpers for sdram_port_arbiter.
// SDRAM_ARB_FIXED_PRIO_EN switches the tie-break from round-robin to display-first.
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef logic mid_t;
  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

  // State values are plain constants so existing netlists keep the same encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;

  function automatic state_t own_state(input mid_t id);
    return (id == M1) ? OWN1 : OWN0;
  endfunction

  // Winner of an arbitration from IDLE; at least one request is assumed present.
  function automatic mid_t arb_pick(input logic req0, input logic req1, input mid_t last);
    mid_t win;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    win = req1 ? M1 : M0;
`else
    if (req0 && req1) win = (last == M0) ? M1 : M0;
    else              win = req1 ? M1 : M0;
`endif
    return win;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Requester-id FIFO for outstanding SDRAM reads; its occupancy is the pending-read count.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int MAX_PEND = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  mid_t push_id,
  input  logic pop,
  output mid_t head_id,
  output logic empty,
  output logic full
);

  localparam int PTR_W  = $clog2(MAX_PEND);
  localparam int PEND_W = PTR_W + 1;

  mid_t              mem [MAX_PEND];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PEND_W-1:0] pend_cnt;
  logic              push_ok, pop_ok;

  assign empty   = (pend_cnt == '0);
  assign full    = (pend_cnt == PEND_W'(MAX_PEND));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_id = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it was written, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester burst arbiter for one Avalon-MM SDRAM port with read-return routing.
// Define SDRAM_ARB_FIXED_PRIO_EN to give m1 (display) priority instead of round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int MAX_PEND  = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable_n,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_read_n,
  input  logic              m0_write_n,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable_n,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_read_n,
  input  logic              m1_write_n,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [BE_W-1:0]   sdram_byteenable_n,
  output logic [DATA_W-1:0] sdram_writedata,
  output logic              sdram_chipselect,
  output logic              sdram_read_n,
  output logic              sdram_write_n,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_readdatavalid,
  input  logic              sdram_waitrequest,
  output logic              err_unexp_rdv
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t           state, state_d;
  mid_t             last_served, own_id, head_id;
  logic [CNT_W-1:0] beat_cnt;
  logic req0, req1, req_other, owned, sel1, gnt_req;
  logic gnt_read_n, gnt_write_n, throttle, fwd_read, fwd_write, fwd_cmd;
  logic accept, burst_done, tag_empty, tag_full, tag_pop;

  assign req0      = !m0_read_n || !m0_write_n;
  assign req1      = !m1_read_n || !m1_write_n;
  assign owned     = (state != IDLE);
  assign sel1      = (state == OWN1);
  assign own_id    = sel1 ? M1 : M0;
  assign gnt_req   = owned && (sel1 ? req1 : req0);
  assign req_other = sel1 ? req0 : req1;

  // Command path is a pure mux: the granted requester talks straight to the controller.
  assign gnt_read_n         = owned ? (sel1 ? m1_read_n  : m0_read_n)  : 1'b1;
  assign gnt_write_n        = owned ? (sel1 ? m1_write_n : m0_write_n) : 1'b1;
  assign sdram_address      = sel1 ? m1_address      : m0_address;
  assign sdram_byteenable_n = sel1 ? m1_byteenable_n : m0_byteenable_n;
  assign sdram_writedata    = sel1 ? m1_writedata    : m0_writedata;

  // A read with the tag FIFO full is held back but still counts as a live request.
  assign throttle   = !gnt_read_n && tag_full;
  assign fwd_read   = !gnt_read_n && !tag_full;
  assign fwd_write  = !gnt_write_n;
  assign fwd_cmd    = fwd_read || fwd_write;
  assign accept     = fwd_cmd && !sdram_waitrequest;
  assign burst_done = accept && (beat_cnt == CNT_W'(BURST_LEN - 1));

  assign sdram_read_n     = !fwd_read;
  assign sdram_write_n    = !fwd_write;
  assign sdram_chipselect = fwd_cmd;

  assign m0_waitrequest = (state == OWN0) ? (throttle || sdram_waitrequest) : 1'b1;
  assign m1_waitrequest = (state == OWN1) ? (throttle || sdram_waitrequest) : 1'b1;

  assign tag_pop          = sdram_readdatavalid && !tag_empty;
  assign m0_readdatavalid = tag_pop && (head_id == M0);
  assign m1_readdatavalid = tag_pop && (head_id == M1);
  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;

  sdram_arb_tag_fifo #(.MAX_PEND(MAX_PEND)) u_tag_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (accept && fwd_read),
    .push_id (own_id),
    .pop     (tag_pop),
    .head_id (head_id),
    .empty   (tag_empty),
    .full    (tag_full)
  );

  // NOTE: state_d is assigned before the case so every path has a value and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req0 || req1) state_d = own_state(arb_pick(req0, req1, last_served));
      end
      OWN0, OWN1: begin
        if (burst_done) begin
          state_d = req_other ? own_state(~own_id) : state;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
          if (own_id == M1 && req1) state_d = OWN1;
`endif
        end else if (!gnt_req) begin
          state_d = req_other ? own_state(~own_id) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      last_served   <= M1;
      beat_cnt      <= '0;
      err_unexp_rdv <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d != IDLE) last_served <= (state_d == OWN1) ? M1 : M0;
      if (burst_done || !gnt_req) beat_cnt <= '0;
      else if (accept)            beat_cnt <= beat_cnt + 1'b1;
      if (sdram_readdatavalid && tag_empty) err_unexp_rdv <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a per-cycle vector table plus multi-cycle sequences.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic              reset_reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable_n, m1_byteenable_n;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_read_n, m0_write_n, m1_read_n, m1_write_n;
  logic [DATA_W-1:0] sdram_readdata;
  logic              sdram_readdatavalid, sdram_waitrequest;

  logic [DATA_W-1:0] m0_readdata, m1_readdata, sdram_writedata;
  logic              m0_readdatavalid, m0_waitrequest, m1_readdatavalid, m1_waitrequest;
  logic [ADDR_W-1:0] sdram_address;
  logic [BE_W-1:0]   sdram_byteenable_n;
  logic              sdram_chipselect, sdram_read_n, sdram_write_n, err_unexp_rdv;

  logic [DATA_W-1:0] b_m0_readdata, b_m1_readdata, b_sdram_writedata;
  logic              b_m0_readdatavalid, b_m0_waitrequest, b_m1_readdatavalid, b_m1_waitrequest;
  logic [ADDR_W-1:0] b_sdram_address;
  logic [BE_W-1:0]   b_sdram_byteenable_n;
  logic              b_sdram_chipselect, b_sdram_read_n, b_sdram_write_n, b_err_unexp_rdv;

  sdram_port_arbiter #(.BURST_LEN(8), .MAX_PEND(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_byteenable_n(m0_byteenable_n), .m0_writedata(m0_writedata),
    .m0_read_n(m0_read_n), .m0_write_n(m0_write_n), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable_n(m1_byteenable_n), .m1_writedata(m1_writedata),
    .m1_read_n(m1_read_n), .m1_write_n(m1_write_n), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
    .sdram_address(sdram_address), .sdram_byteenable_n(sdram_byteenable_n),
    .sdram_writedata(sdram_writedata), .sdram_chipselect(sdram_chipselect),
    .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
    .sdram_waitrequest(sdram_waitrequest), .err_unexp_rdv(err_unexp_rdv)
  );

  // Second instance with single-beat grants for the interleaved-read routing sequence.
  sdram_port_arbiter #(.BURST_LEN(1), .MAX_PEND(8)) dut_b (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_byteenable_n(m0_byteenable_n), .m0_writedata(m0_writedata),
    .m0_read_n(m0_read_n), .m0_write_n(m0_write_n), .m0_readdata(b_m0_readdata),
    .m0_readdatavalid(b_m0_readdatavalid), .m0_waitrequest(b_m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable_n(m1_byteenable_n), .m1_writedata(m1_writedata),
    .m1_read_n(m1_read_n), .m1_write_n(m1_write_n), .m1_readdata(b_m1_readdata),
    .m1_readdatavalid(b_m1_readdatavalid), .m1_waitrequest(b_m1_waitrequest),
    .sdram_address(b_sdram_address), .sdram_byteenable_n(b_sdram_byteenable_n),
    .sdram_writedata(b_sdram_writedata), .sdram_chipselect(b_sdram_chipselect),
    .sdram_read_n(b_sdram_read_n), .sdram_write_n(b_sdram_write_n),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
    .sdram_waitrequest(sdram_waitrequest), .err_unexp_rdv(b_err_unexp_rdv)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // {m0_wait, m1_wait, sdram_read_n, sdram_write_n, chipselect, m0_rdv, m1_rdv, err}
  function automatic logic [7:0] outs();
    return {m0_waitrequest, m1_waitrequest, sdram_read_n, sdram_write_n,
            sdram_chipselect, m0_readdatavalid, m1_readdatavalid, err_unexp_rdv};
  endfunction

  task automatic idle_inputs();
    m0_read_n = 1'b1; m0_write_n = 1'b1; m1_read_n = 1'b1; m1_write_n = 1'b1;
    m0_address = '0; m1_address = 25'h0_0800; m0_byteenable_n = 2'b00; m1_byteenable_n = 2'b01;
    m0_writedata = 16'h1111; m1_writedata = 16'h2222;
    sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0; sdram_readdata = 16'hA5C3;
  endtask

  task automatic next_cycle();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    idle_inputs();
    #1;
    check("reset_outputs", {24'd0, outs()}, 32'h0000_00F0);
    repeat (2) next_cycle();
    reset_reset_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] ins;   // {m0_read_n, m0_write_n, m1_read_n, m1_write_n, sdram_wait, sdram_rdv}
    logic [7:0] exp;
  } vec_t;

  vec_t vt [12];

  initial begin
    int k, acc_first, acc_last, bad, m1w_bad, own, exp_own, first_own, bubbles;
    int acc, ret, r0, r1, n;
    logic [3:0] order;
    logic [7:0] route;

    vt[0]  = '{6'b111100, 8'b1111_0000};
    vt[1]  = '{6'b011100, 8'b1111_0000};
    vt[2]  = '{6'b011110, 8'b1101_1000};
    vt[3]  = '{6'b011100, 8'b0101_1000};
    vt[4]  = '{6'b111001, 8'b0111_0100};
    vt[5]  = '{6'b111000, 8'b1010_1000};
    vt[6]  = '{6'b110100, 8'b1001_1000};
    vt[7]  = '{6'b111101, 8'b1011_0010};
    vt[8]  = '{6'b111101, 8'b1111_0000};
    vt[9]  = '{6'b111100, 8'b1111_0001};
    vt[10] = '{6'b101100, 8'b1111_0001};
    vt[11] = '{6'b101100, 8'b0110_1001};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      {m0_read_n, m0_write_n, m1_read_n, m1_write_n, sdram_waitrequest, sdram_readdatavalid} = vt[i].ins;
      #1;
      check($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vt[i].exp});
      if (i == 4) check("readdata_bcast", {m0_readdata, m1_readdata}, 32'hA5C3_A5C3);
      next_cycle();
    end

    // m0 writes 20 words alone: bursts re-granted back-to-back.
    do_reset();
    k = 0; acc_first = -1; acc_last = -1; bad = 0; m1w_bad = 0;
    for (int c = 0; c < 40; c++) begin
      m0_write_n = (k < 20) ? 1'b0 : 1'b1;
      m0_address = 25'h100 + 25'(k);
      m0_writedata = 16'h3000 + 16'(k);
      m0_byteenable_n = 2'(k);
      #1;
      if (m1_waitrequest !== 1'b1) m1w_bad++;
      if (sdram_write_n === 1'b0 && sdram_chipselect === 1'b1) begin
        if (sdram_address !== 25'h100 + 25'(k) || sdram_writedata !== 16'h3000 + 16'(k) ||
            sdram_byteenable_n !== 2'(k)) bad++;
        if (acc_first < 0) acc_first = c;
        acc_last = c;
        k++;
      end
      next_cycle();
    end
    check("wr20_count", k, 20);
    check("wr20_latency", acc_first, 1);
    check("wr20_no_bubble", acc_last - acc_first, 19);
    check("wr20_mux", bad, 0);
    check("wr20_m1_wait", m1w_bad, 0);

    // Both request continuously from reset.
    do_reset();
    m0_write_n = 1'b0; m1_write_n = 1'b0;
    bad = 0; bubbles = 0; first_own = 2;
    for (int c = 0; c < 33; c++) begin
      #1;
      own = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_own = (c == 0) ? 2 : 1;
`else
      exp_own = (c == 0) ? 2 : ((c - 1) / 8) % 2;
`endif
      if (own != exp_own) bad++;
      if (c == 1) first_own = own;
      if (c >= 1 && sdram_write_n !== 1'b0) bubbles++;
      next_cycle();
    end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    check("first_grant", first_own, 1);
`else
    check("first_grant", first_own, 0);
`endif
    check("grant_sequence", bad, 0);
    check("switch_bubbles", bubbles, 0);

    // m1 reads: ninth read throttled until the first beat returns.
    do_reset();
    acc = 0; ret = 0; r0 = 0; r1 = 0; bad = 0; m1w_bad = 0;
    m1_read_n = 1'b0;
    for (int c = 0; c < 20 && acc < 8; c++) begin
      m1_address = 25'h1_0000 + 25'(acc);
      #1;
      if (sdram_read_n === 1'b0 && !sdram_waitrequest) begin
        if (sdram_address !== 25'h1_0000 + 25'(acc)) bad++;
        acc++;
      end
      next_cycle();
    end
    check("rd_fill", acc, 8);
    m1_address = 25'h1_0000 + 25'(acc);
    for (int c = 0; c < 3; c++) begin
      #1;
      if (m1_waitrequest !== 1'b1 || sdram_read_n !== 1'b1 || sdram_chipselect !== 1'b0) m1w_bad++;
      next_cycle();
    end
    check("rd_throttle", m1w_bad, 0);
    sdram_readdatavalid = 1'b1; sdram_readdata = 16'h5A00;
    #1;
    check("rd_first_beat", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd1);
    check("rd_first_data", m1_readdata, 16'h5A00);
    check("rd_throttle_pop_cycle", sdram_read_n, 1'b1);
    ret = 1; r1 = 1;
    next_cycle();
    sdram_readdatavalid = 1'b0;
    #1;
    check("rd_ninth_forwarded", sdram_read_n, 1'b0);
    if (sdram_read_n === 1'b0 && !sdram_waitrequest) acc++;
    next_cycle();
    for (int c = 0; c < 80 && ret < 10; c++) begin
      m1_read_n = (acc < 10) ? 1'b0 : 1'b1;
      m1_address = 25'h1_0000 + 25'(acc);
      sdram_readdatavalid = (acc > ret);
      sdram_readdata = 16'h5A00 + 16'(ret);
      #1;
      if (sdram_readdatavalid) ret++;
      if (m1_readdatavalid) r1++;
      if (m0_readdatavalid) r0++;
      if (sdram_read_n === 1'b0 && !sdram_waitrequest) begin
        if (sdram_address !== 25'h1_0000 + 25'(acc)) bad++;
        acc++;
      end
      next_cycle();
    end
    idle_inputs();
    check("rd_accepted", acc, 10);
    check("rd_returned", ret, 10);
    check("rd_m1_beats", r1, 10);
    check("rd_m0_beats", r0, 0);
    check("rd_addr", bad, 0);
    check("rd_no_err", err_unexp_rdv, 1'b0);

    // Interleaved single-beat grants on the BURST_LEN = 1 instance.
    do_reset();
    m0_read_n = 1'b0; m1_read_n = 1'b0;
    n = 0; order = '0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (b_sdram_read_n === 1'b0 && !sdram_waitrequest) begin
        order[n] = b_m0_waitrequest;
        n++;
      end
      next_cycle();
    end
    m0_read_n = 1'b1; m1_read_n = 1'b1;
    route = '0;
    for (int i = 0; i < 4; i++) begin
      sdram_readdatavalid = 1'b1;
      #1;
      route[2*i +: 2] = {b_m1_readdatavalid, b_m0_readdatavalid};
      next_cycle();
    end
    sdram_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    check("interleave_grant", order, 4'b1111);
    check("interleave_route", route, 8'b1010_1010);
`else
    check("interleave_grant", order, 4'b1010);
    check("interleave_route", route, 8'b1001_1001);
`endif

    // Reset with reads outstanding drops the tags; a late beat is then unexpected.
    do_reset();
    m0_read_n = 1'b0;
    repeat (3) next_cycle();
    do_reset();
    sdram_readdatavalid = 1'b1;
    #1;
    check("late_rdv_unrouted", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
    next_cycle();
    sdram_readdatavalid = 1'b0;
    repeat (3) next_cycle();
    check("err_sticky", err_unexp_rdv, 1'b1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
